pipe_elastic_reg: RTL and testbench
===================================

Name: pipe_elastic_reg

Overview:
- Parametrised elastic pipeline register: the successor to the fixed stall/flush stage registers between processor stages.
- Replaces the global stall wire with a per-stage valid/ready handshake, so a downstream stall back-pressures only as far as needed.
- Provides DEPTH chained stages of WIDTH-bit payload, an optional skid slot per stage for full throughput with a registered in_ready, synchronous flush, and an occupancy count.
- Sits between any two pipeline stages or functional units; the payload is an opaque packed control/data bus.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- DEPTH, 1, number of chained stages (>=1).
- SKID, 1, 1 = each stage has main and skid slots and in_ready is a pure register output; 0 = main slot only, in_ready combinational.
- RST_VAL, 0, WIDTH-bit value loaded into every data slot on reset and on flush.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  chain can accept a beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head entry.
- out_data  out  WIDTH  head payload.
- occupancy  out  $clog2(DEPTH*(1+SKID)+1)  number of valid entries held in the chain.

Behaviour:
- Reset (async, rst=1): all valid bits 0, all data slots = RST_VAL, occupancy 0; out_valid=0, out_data=RST_VAL. With SKID=1, in_ready=1 during and after reset.
- Handshake: a beat transfers when valid & ready are both high at a rising edge. in_valid must not depend on in_ready. Payload is stable while valid and not ready, and is not checked otherwise.
- Stage k output feeds stage k+1 input; stage 0 is the chain input and stage DEPTH-1 is the chain output.
- SKID=1 stage:
  - Slots: main (M) and skid (S). stage_in_ready = ~S.valid (registered).
  - Accept with M empty, or with M draining this cycle: beat goes to M.
  - Accept with M full and not draining: beat goes to S.
  - M drains while S is full: S moves to M and S clears.
  - Order is always M older than S.
- SKID=0 stage: stage_in_ready = ~M.valid | stage_out_ready (combinational). Accept loads M. Drain without accept clears M.valid.
- Latency: a beat into an empty chain appears at out_valid exactly DEPTH cycles after acceptance. Steady-state throughput is 1 beat/cycle with out_ready held high.
- Capacity: DEPTH*(1+SKID) entries. When full, in_ready=0 until out_ready pops an entry. With SKID=1, in_ready rises the cycle after the pop edge.
- occupancy: +1 on input accept, -1 on output pop, unchanged when both occur in the same cycle. Never exceeds capacity and never underflows.
- Flush (priority over all other events):
  - At the edge with flush=1, every valid bit clears, every data slot loads RST_VAL, and occupancy becomes 0.
  - A beat handshaked at the input in the flush cycle is discarded.
  - An output pop in the flush cycle counts as consumed downstream.
  - in_ready is not gated by flush.
- Flush and rst together: rst dominates. Reset mid-transfer drops all entries with no partial state.
- Data slots load only on accept or transfer; they are never enabled when the beat is not valid.
- Each stage holds on back-pressure and never duplicates or drops a beat other than through flush.

Decomposition:
- Shared package pipe_pkg: default WIDTH, RST_VAL constants, and a function computing the occupancy width from DEPTH and SKID.
- Sub-module pipe_elastic_slot implements one stage (M plus optional S) with its own handshake.
- Top level instantiates DEPTH slots in a generate loop and keeps the occupancy counter.

Test Plan:
- Reset/idle: WIDTH=16, DEPTH=2, RST_VAL=16'hDEAD; assert rst mid-cycle -> out_valid=0, out_data=16'hDEAD, occupancy=0, in_ready=1 (SKID=1) immediately, without a clock edge.
- Streaming: DEPTH=3, SKID=1, out_ready=1; push 0x0001..0x0010 back-to-back -> first beat at out_valid 3 cycles after its accept, then 16 consecutive beats in order, in_ready constantly 1.
- Back-pressure fill: DEPTH=2, SKID=1, out_ready=0; push 0xA0..0xA5 -> 4 accepted, in_ready=0 after the 4th, occupancy=4. Release out_ready for 1 cycle -> 0xA0 pops, in_ready=1 the next cycle, occupancy=3.
- Random stall: SKID=0 and SKID=1, DEPTH=4, random in_valid/out_ready for 10k cycles -> scoreboard output equals input order, occupancy matches a model, nothing lost or duplicated.
- Flush: chain holding 3 entries; pulse flush while in_valid=1 (data 0x55) and out_ready=1 -> next cycle out_valid=0, occupancy=0, 0x55 never emerges, out_data=RST_VAL.
- Simultaneous accept/pop at full capacity with SKID=0 -> in_ready=1 combinationally, occupancy unchanged, order preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and sizing helpers for the elastic pipeline register.
package pipe_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RST_VAL = '0;

   // Counter width able to hold 0..DEPTH*(1+SKID) entries.
   function automatic int unsigned occ_width(input int unsigned depth, input int unsigned skid);
      return $clog2(depth * (1 + skid) + 1);
   endfunction

endpackage

// File: rtl/pipe_elastic_slot.sv
// One elastic stage: main slot plus optional skid slot, valid/ready on both sides.
module pipe_elastic_slot
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned      SKID    = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             accept;
   logic             drain;

   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign accept    = in_valid & in_ready;
   assign drain     = m_valid & out_ready;

   if (SKID != 0) begin : g_skid
      logic             s_valid;
      logic [WIDTH-1:0] s_data;

      // Ready depends only on the skid register, breaking the ready path.
      assign in_ready = ~s_valid;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= RST_VAL;
            s_data  <= RST_VAL;
         end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= RST_VAL;
            s_data  <= RST_VAL;
         end else if (drain) begin
            if (s_valid) begin
               m_data  <= s_data;
               s_valid <= 1'b0;
            end else if (accept) begin
               m_data <= in_data;
            end else begin
               m_valid <= 1'b0;
            end
         end else if (accept) begin
            if (m_valid) begin
               s_valid <= 1'b1;
               s_data  <= in_data;
            end else begin
               m_valid <= 1'b1;
               m_data  <= in_data;
            end
         end
      end
   end else begin : g_noskid
      assign in_ready = ~m_valid | out_ready;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            m_valid <= 1'b0;
            m_data  <= RST_VAL;
         end else if (flush) begin
            m_valid <= 1'b0;
            m_data  <= RST_VAL;
         end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
         end else if (drain) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipe_elastic_reg.sv
// Chain of DEPTH elastic stages with a running occupancy count.
module pipe_elastic_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned      DEPTH   = 1,
   parameter int unsigned      SKID    = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WIDTH-1:0]                    out_data,
   output logic [occ_width(DEPTH, SKID)-1:0]   occupancy
);

   localparam int unsigned OCC_W = occ_width(DEPTH, SKID);

   logic [DEPTH:0]            v;
   logic [DEPTH:0]            r;
   logic [DEPTH:0][WIDTH-1:0] d;
   logic                      push;
   logic                      pop;

   assign v[0]      = in_valid;
   assign d[0]      = in_data;
   assign in_ready  = r[0];
   assign out_valid = v[DEPTH];
   assign out_data  = d[DEPTH];
   assign r[DEPTH]  = out_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_elastic_slot #(
         .WIDTH   (WIDTH),
         .SKID    (SKID),
         .RST_VAL (RST_VAL)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (v[k]),
         .in_ready  (r[k]),
         .in_data   (d[k]),
         .out_valid (v[k+1]),
         .out_ready (r[k+1]),
         .out_data  (d[k+1])
      );
   end

   assign push = in_valid & r[0];
   assign pop  = v[DEPTH] & out_ready;

   // Entry count; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (push && !pop) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (pop && !push) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed and randomised checks of pipe_elastic_reg across several configurations.
module tb_pipe_elastic_reg;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // A: DEPTH=2 SKID=1 RST_VAL=DEAD
   logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
   logic [15:0] a_in_data = '0, a_out_data;
   logic [2:0]  a_occ;
   // B: DEPTH=3 SKID=1
   logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
   logic [15:0] b_in_data = '0, b_out_data;
   logic [2:0]  b_occ;
   // C: DEPTH=4 SKID=0
   logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
   logic [15:0] c_in_data = '0, c_out_data;
   logic [2:0]  c_occ;
   // D: DEPTH=4 SKID=1
   logic d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
   logic [15:0] d_in_data = '0, d_out_data;
   logic [3:0]  d_occ;

   pipe_elastic_reg #(.WIDTH(16), .DEPTH(2), .SKID(1), .RST_VAL(16'hDEAD)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .occupancy(a_occ));
   pipe_elastic_reg #(.WIDTH(16), .DEPTH(3), .SKID(1), .RST_VAL(16'h0000)) u_b (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .occupancy(b_occ));
   pipe_elastic_reg #(.WIDTH(16), .DEPTH(4), .SKID(0), .RST_VAL(16'h0000)) u_c (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .occupancy(c_occ));
   pipe_elastic_reg #(.WIDTH(16), .DEPTH(4), .SKID(1), .RST_VAL(16'h0000)) u_d (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_data(d_out_data), .occupancy(d_occ));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] cq[$];
   logic [15:0] dq[$];
   logic [15:0] c_seq = 16'h1000, d_seq = 16'h2000;
   logic        c_acc = 0, d_acc = 0;

   initial begin
      // Async reset mid-cycle, checked before any clock edge
      #3 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'h0);
      chk("rst_out_data",  32'(a_out_data),  32'hDEAD);
      chk("rst_occ",       32'(a_occ),       32'h0);
      chk("rst_in_ready",  32'(a_in_ready),  32'h1);
      chk("rst_b_in_ready", 32'(b_in_ready), 32'h1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cyc();
      chk("idle_in_ready", 32'(a_in_ready), 32'h1);
      chk("idle_out_data", 32'(a_out_data), 32'hDEAD);

      // Back-pressure fill of A: 4 entries accepted
      for (int i = 0; i < 4; i++) begin
         cyc();
         a_in_valid = 1'b1;
         a_in_data  = 16'(16'hA0 + i);
         #1;
         chk("bp_in_ready_fill", 32'(a_in_ready), 32'h1);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         a_in_data = 16'hA4;
         #1;
         chk("bp_full_in_ready", 32'(a_in_ready), 32'h0);
         chk("bp_full_occ",      32'(a_occ),      32'h4);
         chk("bp_full_head",     32'(a_out_data), 32'hA0);
      end
      cyc();
      a_out_ready = 1'b1;
      #1;
      chk("bp_pop_valid", 32'(a_out_valid), 32'h1);
      chk("bp_pop_data",  32'(a_out_data),  32'hA0);
      cyc();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b0;
      #1;
      chk("bp_after_pop_occ",  32'(a_occ),      32'h3);
      chk("bp_after_pop_head", 32'(a_out_data), 32'hA1);
      cyc();
      #1;
      chk("bp_in_ready_rise", 32'(a_in_ready), 32'h1);
      chk("bp_occ_held",      32'(a_occ),      32'h3);

      // Flush with a concurrent input beat and output pop
      cyc();
      a_flush     = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 16'h0055;
      a_out_ready = 1'b1;
      #1;
      chk("fl_in_ready_ungated", 32'(a_in_ready), 32'h1);
      cyc();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      #1;
      chk("fl_out_valid", 32'(a_out_valid), 32'h0);
      chk("fl_occ",       32'(a_occ),       32'h0);
      chk("fl_out_data",  32'(a_out_data),  32'hDEAD);
      for (int i = 0; i < 4; i++) begin
         cyc();
         #1;
         chk("fl_no_ghost", 32'(a_out_valid), 32'h0);
      end
      a_out_ready = 1'b0;

      // Streaming through B: latency 3, 16 back-to-back beats
      b_out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         b_in_valid = (k < 16);
         b_in_data  = 16'(k + 1);
         #1;
         if (k < 16) chk("st_in_ready", 32'(b_in_ready), 32'h1);
         chk("st_out_valid", 32'(b_out_valid), 32'((k >= 3) && (k <= 18)));
         if (k >= 3 && k <= 18) chk("st_out_data", 32'(b_out_data), 32'(k - 2));
      end
      b_in_valid = 1'b0;

      // C (SKID=0) fill to capacity, then accept and pop in the same cycle
      for (int i = 0; i < 4; i++) begin
         cyc();
         c_in_valid = 1'b1;
         c_in_data  = 16'(16'hC0 + i);
         #1;
         chk("s0_fill_ready", 32'(c_in_ready), 32'h1);
      end
      cyc();
      c_in_valid = 1'b1;
      c_in_data  = 16'h00C4;
      #1;
      chk("s0_full_ready", 32'(c_in_ready), 32'h0);
      chk("s0_full_occ",   32'(c_occ),      32'h4);
      c_out_ready = 1'b1;
      #1;
      chk("s0_comb_ready", 32'(c_in_ready), 32'h1);
      chk("s0_head",       32'(c_out_data), 32'hC0);
      for (int i = 1; i < 5; i++) begin
         cyc();
         c_in_valid = 1'b0;
         #1;
         if (i == 1) chk("s0_occ_same", 32'(c_occ), 32'h4);
         chk("s0_order", 32'(c_out_data), 32'(16'hC0 + i));
      end
      cyc();
      #1;
      chk("s0_empty", 32'(c_occ), 32'h0);
      c_out_ready = 1'b0;

      // Random stall on C (SKID=0) and D (SKID=1) against queue scoreboards
      for (int n = 0; n < 10000; n++) begin
         cyc();
         if (c_acc) c_in_valid = 1'b0;
         if (d_acc) d_in_valid = 1'b0;
         if (!c_in_valid && $urandom_range(0, 3) != 0) begin
            c_in_valid = 1'b1; c_in_data = c_seq; c_seq++;
         end
         if (!d_in_valid && $urandom_range(0, 3) != 0) begin
            d_in_valid = 1'b1; d_in_data = d_seq; d_seq++;
         end
         c_out_ready = 1'($urandom_range(0, 1));
         d_out_ready = 1'($urandom_range(0, 1));
         #1;
         if (bad < 20) begin
            chk("rc_occ", 32'(c_occ), 32'(cq.size()));
            chk("rd_occ", 32'(d_occ), 32'(dq.size()));
            if (cq.size() == 0) chk("rc_empty_valid", 32'(c_out_valid), 32'h0);
            if (dq.size() == 0) chk("rd_empty_valid", 32'(d_out_valid), 32'h0);
            if (cq.size() == 0) chk("rc_empty_ready", 32'(c_in_ready), 32'h1);
            if (dq.size() == 0) chk("rd_empty_ready", 32'(d_in_ready), 32'h1);
            if (cq.size() == 4) chk("rc_full_ready", 32'(c_in_ready), 32'(c_out_ready));
            if (dq.size() == 8) chk("rd_full_ready", 32'(d_in_ready), 32'h0);
         end
         c_acc = c_in_valid & c_in_ready;
         d_acc = d_in_valid & d_in_ready;
         if (c_out_valid && c_out_ready) begin
            if (cq.size() == 0) chk("rc_pop_underflow", 32'h1, 32'h0);
            else chk("rc_data", 32'(c_out_data), 32'(cq.pop_front()));
         end
         if (d_out_valid && d_out_ready) begin
            if (dq.size() == 0) chk("rd_pop_underflow", 32'h1, 32'h0);
            else chk("rd_data", 32'(d_out_data), 32'(dq.pop_front()));
         end
         if (c_acc) cq.push_back(c_in_data);
         if (d_acc) dq.push_back(d_in_data);
      end

      // Drain both chains and confirm nothing was lost
      cyc();
      c_in_valid  = 1'b0;
      d_in_valid  = 1'b0;
      c_out_ready = 1'b1;
      d_out_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (c_out_valid) begin
            if (cq.size() == 0) chk("dc_extra", 32'h1, 32'h0);
            else chk("dc_data", 32'(c_out_data), 32'(cq.pop_front()));
         end
         if (d_out_valid) begin
            if (dq.size() == 0) chk("dd_extra", 32'h1, 32'h0);
            else chk("dd_data", 32'(d_out_data), 32'(dq.pop_front()));
         end
         cyc();
      end
      chk("dc_left", 32'(cq.size()), 32'h0);
      chk("dd_left", 32'(dq.size()), 32'h0);
      chk("dc_occ",  32'(c_occ),     32'h0);
      chk("dd_occ",  32'(d_occ),     32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
